vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 48 ++++
 rtl/pixel_tick_div.sv | 38 +++
 rtl/vga_timing_gen.sv | 119 +++++++++++
 tb/tb_vga_timing_gen.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants, coordinate type and sync/window helpers.
// Latency: none (constants and pure functions only).
// Backpressure: not applicable.
package vga_timing_pkg;

  // Coordinate width; every raster dimension must fit in it.
  localparam int COORD_W   = 10;
  localparam int COORD_MAX = 1 << COORD_W;

  // Colour channel width used by the graphics renderer.
  localparam int COLOR_W = 3;

  // 640x480@60 horizontal timing, in pixels.
  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_SYNC    = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

  // 640x480@60 vertical timing, in lines.
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_SYNC    = 2;
  localparam int VGA_V_BACK    = 33;
  localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

  // 100 MHz system clock down to the 25 MHz pixel rate.
  localparam int VGA_CLK_DIV = 4;

  // One raster position.
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // Drive a sync line: the active level is pol, the idle level its inverse.
  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

  // Half-open window test lo <= c < hi.
  function automatic logic in_window(input logic [COORD_W-1:0] c,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (c >= lo) && (c < hi);
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Clock-enable divider: tick is high for one clk out of every CLK_DIV clks.
// Latency: first tick is the clk in which div_cnt reaches CLK_DIV-1 (CLK_DIV-1 edges after reset).
// Backpressure: none, free-running.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  // A 1-bit counter still works for CLK_DIV = 1: it simply stays at 0.
  localparam int              DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  generate
    if (CLK_DIV < 1) begin : g_bad_div
      $error("pixel_tick_div: CLK_DIV must be 1 or more");
    end
  endgenerate

  logic [DIV_W-1:0] div_cnt;

  // Count 0..CLK_DIV-1 and wrap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // With CLK_DIV = 1 the compare is always true, so tick is held high.
  assign tick = (div_cnt == DIV_LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Raster-scan timing: pixel enable, coordinates, video_on, h/v sync, line and frame ticks.
// Latency: outputs are a registered decode of the coordinate the counters load on the same edge,
//          so p_tick, pix_x/pix_y, video_on, syncs and line/frame ticks all change together.
// Backpressure: none; free-running, consumers sample on p_tick.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_SYNC    = VGA_H_SYNC,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_SYNC    = VGA_V_SYNC,
  parameter int V_BACK    = VGA_V_BACK,
  parameter int CLK_DIV   = VGA_CLK_DIV,
  parameter bit SYNC_POL  = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  output logic               p_tick,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               video_on,
  output logic               hsync,
  output logic               vsync,
  output logic               line_tick,
  output logic               frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > COORD_MAX) begin : g_bad_h
      $error("vga_timing_gen: H_TOTAL does not fit the coordinate width");
    end
    if (V_TOTAL > COORD_MAX) begin : g_bad_v
      $error("vga_timing_gen: V_TOTAL does not fit the coordinate width");
    end
  endgenerate

  // Raster landmarks at coordinate width.
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_VIS  = COORD_W'(H_DISPLAY);
  localparam logic [COORD_W-1:0] V_VIS  = COORD_W'(V_DISPLAY);
  localparam logic [COORD_W-1:0] HS_ON  = COORD_W'(H_DISPLAY + H_FRONT);
  localparam logic [COORD_W-1:0] HS_OFF = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_ON  = COORD_W'(V_DISPLAY + V_FRONT);
  localparam logic [COORD_W-1:0] VS_OFF = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC);

  logic   tick;
  coord_t pos;
  coord_t pos_nxt;
  logic   h_wrap;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_pixel_tick_div (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  // Next raster position: step h on each tick, step v on the h wrap.
  always_comb begin
    pos_nxt = pos;
    h_wrap  = 1'b0;
    if (tick) begin
      if (pos.x == H_LAST) begin
        pos_nxt.x = '0;
        h_wrap    = 1'b1;
        if (pos.y == V_LAST) begin
          pos_nxt.y = '0;
        end else begin
          pos_nxt.y = pos.y + 1'b1;
        end
      end else begin
        pos_nxt.x = pos.x + 1'b1;
      end
    end
  end

  // Horizontal and vertical counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos <= '0;
    end else begin
      pos <= pos_nxt;
    end
  end

  // Output stage: decode the coordinate being loaded so every output describes the same pixel
  // and p_tick marks the edge on which that pixel appears.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      p_tick     <= 1'b0;
      line_tick  <= 1'b0;
      frame_tick <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      video_on   <= 1'b0;
      hsync      <= ~SYNC_POL;
      vsync      <= ~SYNC_POL;
    end else begin
      p_tick     <= tick;
      line_tick  <= h_wrap;
      // Entering (0, V_DISPLAY) is the start of vertical blanking.
      frame_tick <= h_wrap && (pos_nxt.y == V_VIS);
      pix_x      <= pos_nxt.x;
      pix_y      <= pos_nxt.y;
      video_on   <= (pos_nxt.x < H_VIS) && (pos_nxt.y < V_VIS);
      hsync      <= sync_level(in_window(pos_nxt.x, HS_ON, HS_OFF), SYNC_POL);
      vsync      <= sync_level(in_window(pos_nxt.y, VS_ON, VS_OFF), SYNC_POL);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: three instances (default 640x480 CLK_DIV=4,
// CLK_DIV=1 with active-high sync, and a tiny raster for whole-frame checks).
// Expected pixels are queued before each run; a monitor pops one per p_tick.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       vid;
    logic       hs;
    logic       vs;
    logic       lt;
    logic       ft;
  } pix_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n      [3];
  logic       p_tick     [3];
  logic [9:0] pix_x      [3];
  logic [9:0] pix_y      [3];
  logic       video_on   [3];
  logic       hsync      [3];
  logic       vsync      [3];
  logic       line_tick  [3];
  logic       frame_tick [3];

  int   checks = 0;
  int   errors = 0;
  pix_t exp_q [3][$];

  vga_timing_gen u_a (
    .clk(clk), .reset(rst_n[0]), .p_tick(p_tick[0]), .pix_x(pix_x[0]), .pix_y(pix_y[0]),
    .video_on(video_on[0]), .hsync(hsync[0]), .vsync(vsync[0]),
    .line_tick(line_tick[0]), .frame_tick(frame_tick[0])
  );

  vga_timing_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_b (
    .clk(clk), .reset(rst_n[1]), .p_tick(p_tick[1]), .pix_x(pix_x[1]), .pix_y(pix_y[1]),
    .video_on(video_on[1]), .hsync(hsync[1]), .vsync(vsync[1]),
    .line_tick(line_tick[1]), .frame_tick(frame_tick[1])
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(2), .SYNC_POL(1'b0)
  ) u_c (
    .clk(clk), .reset(rst_n[2]), .p_tick(p_tick[2]), .pix_x(pix_x[2]), .pix_y(pix_y[2]),
    .video_on(video_on[2]), .hsync(hsync[2]), .vsync(vsync[2]),
    .line_tick(line_tick[2]), .frame_tick(frame_tick[2])
  );

  task automatic cmp(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Queue the expected pixel for p_tick number 1..n after reset release.
  task automatic push_run(input int d, input int n, input int htot, input int vtot,
                          input int hd, input int vd, input int hs0, input int hs1,
                          input int vs0, input int vs1, input bit pol);
    pix_t e;
    int   x;
    int   y;
    exp_q[d].delete();
    for (int k = 1; k <= n; k++) begin
      x     = k % htot;
      y     = (k / htot) % vtot;
      e.x   = 10'(x);
      e.y   = 10'(y);
      e.vid = (x < hd) && (y < vd);
      e.hs  = ((x >= hs0) && (x < hs1)) ? pol : ~pol;
      e.vs  = ((y >= vs0) && (y < vs1)) ? pol : ~pol;
      e.lt  = (x == 0);
      e.ft  = (x == 0) && (y == vd);
      exp_q[d].push_back(e);
    end
  endtask

  task automatic monitor_dut(input int d);
    pix_t act;
    pix_t want;
    cmp($sformatf("tick_gate_%0d", d), int'((line_tick[d] | frame_tick[d]) & ~p_tick[d]), 0);
    if (p_tick[d]) begin
      act = {pix_x[d], pix_y[d], video_on[d], hsync[d], vsync[d], line_tick[d], frame_tick[d]};
      checks++;
      if (exp_q[d].size() == 0) begin
        errors++;
        $display("FAIL sb_extra_%0d: p_tick at x=%0d y=%0d with nothing expected", d, act.x, act.y);
      end else begin
        want = exp_q[d].pop_front();
        if (act != want) begin
          errors++;
          $display("FAIL sb_pix_%0d: got x=%0d y=%0d vid=%b hs=%b vs=%b lt=%b ft=%b, expected x=%0d y=%0d vid=%b hs=%b vs=%b lt=%b ft=%b",
                   d, act.x, act.y, act.vid, act.hs, act.vs, act.lt, act.ft,
                   want.x, want.y, want.vid, want.hs, want.vs, want.lt, want.ft);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) monitor_dut(d);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_pt;
    int lt_clk;
    int hs_cnt;
    int hs_fall_x;
    logic prev_hs;
    int pt_cnt;
    int ft_cnt;
    int ft_first;
    int ft_period;
    int lt_cnt;
    int vs_low;
    int wraps;

    rst_n[0] = 1'b0;
    rst_n[1] = 1'b0;
    rst_n[2] = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    cmp("rst_pix_a", int'({pix_x[0], pix_y[0]}), 0);
    cmp("rst_video_a", int'(video_on[0]), 0);
    cmp("rst_sync_a", int'({hsync[0], vsync[0]}), 3);
    cmp("rst_ticks_a", int'({p_tick[0], line_tick[0], frame_tick[0]}), 0);
    cmp("rst_sync_b", int'({hsync[1], vsync[1]}), 0);

    // Default raster: one line plus a little.
    push_run(0, 810, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0);
    rst_n[0]  = 1'b1;
    first_pt  = -1;
    lt_clk    = -1;
    hs_cnt    = 0;
    hs_fall_x = -1;
    prev_hs   = 1'b1;
    for (int c = 1; c <= 3240; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        cmp("first_edge_pix_a", int'({pix_x[0], pix_y[0]}), 0);
        cmp("first_edge_video_a", int'(video_on[0]), 1);
      end
      if (p_tick[0] && first_pt < 0) first_pt = c;
      if (line_tick[0] && lt_clk < 0) lt_clk = c;
      if (!hsync[0]) hs_cnt++;
      if (prev_hs && !hsync[0]) hs_fall_x = int'(pix_x[0]);
      prev_hs = hsync[0];
    end
    @(negedge clk);
    #1;
    cmp("drain_a", exp_q[0].size(), 0);
    cmp("first_ptick_clk_a", first_pt, 4);
    cmp("line_clks_a", lt_clk, 3200);
    cmp("hsync_low_clks_a", hs_cnt, 384);
    cmp("hsync_fall_x_a", hs_fall_x, 656);

    // Reset pulse in the middle of a line.
    rst_n[0] = 1'b0;
    @(negedge clk);
    #1;
    push_run(0, 300, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0);
    rst_n[0] = 1'b1;
    repeat (1200) @(posedge clk);
    @(negedge clk);
    #1;
    cmp("drain_a_mid", exp_q[0].size(), 0);
    cmp("pre_reset_x_a", int'(pix_x[0]), 300);
    rst_n[0] = 1'b0;
    #1;
    cmp("async_clear_pix_a", int'({pix_x[0], pix_y[0]}), 0);
    cmp("async_clear_video_a", int'(video_on[0]), 0);
    cmp("async_clear_sync_a", int'({hsync[0], vsync[0]}), 3);
    cmp("async_clear_ticks_a", int'({p_tick[0], line_tick[0], frame_tick[0]}), 0);
    repeat (3) @(negedge clk);
    #1;
    push_run(0, 20, 800, 525, 640, 480, 656, 752, 490, 492, 1'b0);
    rst_n[0] = 1'b1;
    first_pt = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        cmp("restart_pix_a", int'({pix_x[0], pix_y[0]}), 0);
        cmp("restart_video_a", int'(video_on[0]), 1);
      end
      if (p_tick[0] && first_pt < 0) first_pt = c;
    end
    @(negedge clk);
    #1;
    cmp("drain_a_restart", exp_q[0].size(), 0);
    cmp("restart_first_ptick_a", first_pt, 4);
    rst_n[0] = 1'b0;

    // CLK_DIV=1, active-high sync.
    push_run(1, 810, 800, 525, 640, 480, 656, 752, 490, 492, 1'b1);
    rst_n[1] = 1'b1;
    pt_cnt   = 0;
    lt_clk   = -1;
    hs_cnt   = 0;
    first_pt = -1;
    for (int c = 1; c <= 810; c++) begin
      @(posedge clk);
      #1;
      if (p_tick[1]) pt_cnt++;
      if (p_tick[1] && first_pt < 0) first_pt = c;
      if (line_tick[1] && lt_clk < 0) lt_clk = c;
      if (hsync[1]) hs_cnt++;
    end
    @(negedge clk);
    #1;
    cmp("drain_b", exp_q[1].size(), 0);
    cmp("first_ptick_clk_b", first_pt, 1);
    cmp("ptick_high_clks_b", pt_cnt, 810);
    cmp("line_clks_b", lt_clk, 800);
    cmp("hsync_high_clks_b", hs_cnt, 96);
    rst_n[1] = 1'b0;

    // Tiny raster (16x10, CLK_DIV=2): two full frames and both wrap corners.
    push_run(2, 325, 16, 10, 8, 6, 10, 13, 7, 9, 1'b0);
    rst_n[2]  = 1'b1;
    ft_cnt    = 0;
    ft_first  = -1;
    ft_period = -1;
    lt_cnt    = 0;
    vs_low    = 0;
    wraps     = 0;
    for (int c = 1; c <= 650; c++) begin
      @(posedge clk);
      #1;
      if (frame_tick[2]) begin
        ft_cnt++;
        if (ft_first < 0) ft_first = c;
        else if (ft_period < 0) ft_period = c - ft_first;
      end
      if (line_tick[2]) lt_cnt++;
      if (!vsync[2]) vs_low++;
      if (line_tick[2] && pix_y[2] == 10'd0) begin
        wraps++;
        cmp("wrap_frame_tick_c", int'(frame_tick[2]), 0);
        cmp("wrap_video_c", int'(video_on[2]), 1);
      end
    end
    @(negedge clk);
    #1;
    cmp("drain_c", exp_q[2].size(), 0);
    cmp("frame_ticks_c", ft_cnt, 2);
    cmp("first_frame_tick_clk_c", ft_first, 192);
    cmp("frame_period_c", ft_period, 320);
    cmp("line_ticks_c", lt_cnt, 20);
    cmp("vsync_low_clks_c", vs_low, 128);
    cmp("wrap_count_c", wraps, 2);
    rst_n[2] = 1'b0;

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
